// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter stage: FSM encoding, default
// geometry and the stack-occupancy width helper.
package pc_sequencer_pkg;

    localparam int AW_DEF    = 4;
    localparam int DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2,
        FAULT  = 2'd3
    } state_t;

    // Occupancy counts 0..depth inclusive, so it needs one bit more than an index.
    function automatic int sp_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Address-mux bus between the sequencer (master) and the external 2:1
// program-memory address mux (slave), which returns the selected address.
interface pc_sequencer_if #(
    parameter int AW = pc_sequencer_pkg::AW_DEF
);
    logic [AW-1:0] mux_d0;
    logic [AW-1:0] mux_d1;
    logic          mux_sel;
    logic [AW-1:0] mux_y;

    modport master (output mux_d0, output mux_d1, output mux_sel, input mux_y);
    modport slave  (input mux_d0, input mux_d1, input mux_sel, output mux_y);
endinterface

// File: rtl/pc_sequencer_ret_stack.sv
// Return-address stack: push/pop with occupancy counter, full/empty flags and
// a combinational top-of-stack read that returns 0 when empty.
module ret_stack
    import pc_sequencer_pkg::*;
#(
    parameter  int AW    = AW_DEF,
    parameter  int DEPTH = DEPTH_DEF,
    localparam int SPW   = sp_width(DEPTH),
    localparam int IW    = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           push,
    input  logic           pop,
    input  logic [AW-1:0]  din,
    output logic [AW-1:0]  top,
    output logic [SPW-1:0] sp,
    output logic           full,
    output logic           empty
);

    logic [AW-1:0]  mem [DEPTH];
    logic [SPW-1:0] sp_q;
    logic [SPW-1:0] sp_dec;

    assign sp     = sp_q;
    assign full   = (sp_q == SPW'(DEPTH));
    assign empty  = (sp_q == '0);
    assign sp_dec = sp_q - SPW'(1);
    assign top    = empty ? '0 : mem[sp_dec[IW-1:0]];

    // Occupancy counter: push and pop are mutually exclusive at the caller.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            sp_q <= '0;
        end else if (push && !full) begin
            sp_q <= sp_q + SPW'(1);
        end else if (pop && !empty) begin
            sp_q <= sp_dec;
        end
    end

    // Entry storage, written at the current occupancy index on push.
    // NOTE: entries are deliberately not reset; only slots below sp are ever read.
    always_ff @(posedge clk) begin
        if (!reset && push && !full) begin
            mem[sp_q[IW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter stage of the fetch path: offers sequential and branch
// candidates to the external address mux, registers the mux result as the
// new PC, and runs the idle/run/halted/fault fetch-control FSM.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter  int AW    = AW_DEF,
    parameter  int DEPTH = DEPTH_DEF,
    localparam int SPW   = sp_width(DEPTH)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           stall,
    input  logic           halt,
    input  logic           jmp,
    input  logic           call,
    input  logic           ret,
    input  logic [AW-1:0]  target,
    pc_sequencer_if.master mbus,
    output logic [AW-1:0]  pc,
    output logic           running,
    output logic           fault,
    output logic [SPW-1:0] sp
);

    state_t        state_q;
    state_t        state_d;
    logic [AW-1:0] pc_q;
    logic [AW-1:0] seq_addr;
    logic [AW-1:0] stack_top;
    logic          adv;
    logic          take_ret;
    logic          take_call;
    logic          ovf;
    logic          unf;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;

    // Control decode: ret outranks call, call outranks jmp.
    assign adv       = (state_q == RUN) && !stall;
    assign take_ret  = adv && ret;
    assign take_call = adv && call && !ret;
    assign unf       = take_ret && empty;
    assign ovf       = take_call && full;
    assign push      = take_call && !full;
    assign pop       = take_ret && !empty;

    assign seq_addr     = pc_q + AW'(1);
    assign mbus.mux_d0  = seq_addr;
    assign mbus.mux_d1  = ret ? stack_top : target;
    assign mbus.mux_sel = adv && (jmp || call || ret) && !ovf && !unf;

    assign pc      = pc_q;
    assign running = (state_q == RUN);
    assign fault   = (state_q == FAULT);

    ret_stack #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (seq_addr),
        .top   (stack_top),
        .sp    (sp),
        .full  (full),
        .empty (empty)
    );

    // PC register: loads the mux result on a clean advance; a stack error freezes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= '0;
        end else if (adv && !ovf && !unf) begin
            pc_q <= mbus.mux_y;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; stall suppresses halt because halt is qualified by adv.
    // NOTE: state_d gets a default first so no path through the case can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = RUN;
            end
            RUN: begin
                if (ovf || unf) begin
                    state_d = FAULT;
                end else if (adv && halt) begin
                    state_d = HALTED;
                end
            end
            HALTED: begin
                if (start) state_d = RUN;
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus randomized traffic, each
// compared against a queue-based behavioural model; the bench also plays the
// external address mux.
module tb_pc_sequencer;

    localparam int AW    = 4;
    localparam int DEPTH = 4;
    localparam int SPW   = $clog2(DEPTH) + 1;

    logic           clk = 1'b0;
    logic           reset, start, stall, halt, jmp, call, ret;
    logic [AW-1:0]  target;
    logic [AW-1:0]  pc;
    logic           running, fault;
    logic [SPW-1:0] sp;

    int n_checks = 0;
    int n_pass   = 0;

    pc_sequencer_if #(.AW(AW)) bus ();

    // External 2:1 address mux.
    assign bus.mux_y = bus.mux_sel ? bus.mux_d1 : bus.mux_d0;

    pc_sequencer #(.AW(AW), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .stall   (stall),
        .halt    (halt),
        .jmp     (jmp),
        .call    (call),
        .ret     (ret),
        .target  (target),
        .mbus    (bus),
        .pc      (pc),
        .running (running),
        .fault   (fault),
        .sp      (sp)
    );

    always #5 clk = ~clk;

    // Behavioural model: PC as an integer, return stack as a queue, mode flags.
    int   m_pc;
    int   m_stk[$];
    bit   m_run, m_halted, m_fault;
    bit   m_adv, m_err;

    logic [AW-1:0]  exp_pc, exp_d0, exp_d1;
    logic [SPW-1:0] exp_sp;
    logic           exp_sel, exp_run, exp_fault;

    task automatic model_reset();
        m_pc = 0;
        m_stk.delete();
        m_run = 0;
        m_halted = 0;
        m_fault = 0;
    endtask

    task automatic model_eval();
        m_adv = m_run && !stall;
        m_err = m_adv && (ret ? (m_stk.size() == 0) : (call && m_stk.size() == DEPTH));
        exp_pc    = AW'(m_pc);
        exp_sp    = SPW'(m_stk.size());
        exp_run   = m_run;
        exp_fault = m_fault;
        exp_d0    = AW'((m_pc + 1) % (1 << AW));
        exp_d1    = ret ? ((m_stk.size() > 0) ? AW'(m_stk[$]) : '0) : target;
        exp_sel   = m_adv && (jmp || call || ret) && !m_err;
    endtask

    task automatic model_clock();
        int nxt;
        model_eval();
        if (reset) begin
            model_reset();
        end else if (m_err) begin
            m_run = 0;
            m_fault = 1;
        end else if (m_adv) begin
            nxt = exp_sel ? int'(exp_d1) : int'(exp_d0);
            if (ret) void'(m_stk.pop_back());
            else if (call) m_stk.push_back(int'(exp_d0));
            m_pc = nxt;
            if (halt) begin
                m_run = 0;
                m_halted = 1;
            end
        end else if (start && !m_run && !m_fault) begin
            m_run = 1;
            m_halted = 0;
        end
    endtask

    // Stimulus helpers: inputs change 1 time unit after posedge, checks happen at negedge.
    task automatic clear_in();
        reset = 0; start = 0; stall = 0; halt = 0;
        jmp = 0; call = 0; ret = 0; target = '0;
    endtask

    task automatic settle();
        @(negedge clk);
        model_eval();
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic run_to(input int v);
        clear_in();
        for (int n = 0; n < 40 && m_pc != v; n++) begin
            settle();
            tick();
        end
    endtask

    task automatic restart();
        clear_in();
        reset = 1;
        settle();
        tick();
        reset = 0;
        start = 1;
        settle();
        tick();
        start = 0;
    endtask

    task automatic test_reset();
        clear_in();
        reset = 1;
        jmp = 1;
        target = 4'h9;
        settle();
        tick();
        tick();
        jmp = 0;
        settle();
        n_checks++; if (pc !== 4'h0) $display("FAIL reset_pc got %h want 0", pc); else n_pass++;
        n_checks++; if (sp !== '0) $display("FAIL reset_sp got %0d want 0", sp); else n_pass++;
        n_checks++; if (running !== 1'b0) $display("FAIL reset_running got %b want 0", running); else n_pass++;
        n_checks++; if (fault !== 1'b0) $display("FAIL reset_fault got %b want 0", fault); else n_pass++;
        n_checks++; if (bus.mux_d0 !== 4'h1) $display("FAIL reset_d0 got %h want 1", bus.mux_d0); else n_pass++;
        n_checks++; if (bus.mux_sel !== 1'b0) $display("FAIL reset_sel got %b want 0", bus.mux_sel); else n_pass++;
        reset = 0;
        tick();
    endtask

    task automatic test_sequential();
        clear_in();
        start = 1;
        settle();
        tick();
        start = 0;
        for (int i = 0; i < 18; i++) begin
            settle();
            n_checks++; if (pc !== AW'(i % 16)) $display("FAIL seq_pc step %0d got %h want %h", i, pc, AW'(i % 16)); else n_pass++;
            n_checks++; if (bus.mux_d0 !== exp_d0) $display("FAIL seq_d0 step %0d got %h want %h", i, bus.mux_d0, exp_d0); else n_pass++;
            n_checks++; if (bus.mux_sel !== 1'b0) $display("FAIL seq_sel step %0d got %b want 0", i, bus.mux_sel); else n_pass++;
            n_checks++; if (running !== 1'b1) $display("FAIL seq_running step %0d got %b want 1", i, running); else n_pass++;
            tick();
        end
    endtask

    task automatic test_jump();
        run_to(3);
        jmp = 1;
        target = 4'hA;
        settle();
        n_checks++; if (bus.mux_sel !== 1'b1) $display("FAIL jmp_sel got %b want 1", bus.mux_sel); else n_pass++;
        n_checks++; if (bus.mux_d1 !== 4'hA) $display("FAIL jmp_d1 got %h want a", bus.mux_d1); else n_pass++;
        tick();
        clear_in();
        settle();
        n_checks++; if (pc !== 4'hA) $display("FAIL jmp_pc got %h want a", pc); else n_pass++;
        tick();
        settle();
        n_checks++; if (pc !== 4'hB) $display("FAIL jmp_pc_next got %h want b", pc); else n_pass++;
        tick();
    endtask

    task automatic test_call_ret();
        run_to(2);
        call = 1;
        target = 4'h8;
        settle();
        n_checks++; if (bus.mux_sel !== 1'b1) $display("FAIL call_sel got %b want 1", bus.mux_sel); else n_pass++;
        tick();
        clear_in();
        settle();
        n_checks++; if (pc !== 4'h8) $display("FAIL call_pc got %h want 8", pc); else n_pass++;
        n_checks++; if (sp !== SPW'(1)) $display("FAIL call_sp got %0d want 1", sp); else n_pass++;
        run_to(9);
        ret = 1;
        settle();
        n_checks++; if (bus.mux_d1 !== 4'h3) $display("FAIL ret_d1 got %h want 3", bus.mux_d1); else n_pass++;
        n_checks++; if (bus.mux_sel !== 1'b1) $display("FAIL ret_sel got %b want 1", bus.mux_sel); else n_pass++;
        tick();
        clear_in();
        settle();
        n_checks++; if (pc !== 4'h3) $display("FAIL ret_pc got %h want 3", pc); else n_pass++;
        n_checks++; if (sp !== '0) $display("FAIL ret_sp got %0d want 0", sp); else n_pass++;
        tick();
    endtask

    task automatic test_overflow();
        logic [AW-1:0] held;
        clear_in();
        for (int i = 0; i < 5; i++) begin
            call = 1;
            target = AW'(3 * i + 1);
            settle();
            n_checks++; if (bus.mux_sel !== exp_sel) $display("FAIL ovf_sel call %0d got %b want %b", i, bus.mux_sel, exp_sel); else n_pass++;
            tick();
        end
        clear_in();
        settle();
        held = exp_pc;
        n_checks++; if (fault !== 1'b1) $display("FAIL ovf_fault got %b want 1", fault); else n_pass++;
        n_checks++; if (running !== 1'b0) $display("FAIL ovf_running got %b want 0", running); else n_pass++;
        n_checks++; if (sp !== SPW'(4)) $display("FAIL ovf_sp got %0d want 4", sp); else n_pass++;
        n_checks++; if (pc !== AW'(10)) $display("FAIL ovf_pc got %h want a", pc); else n_pass++;
        tick();
        start = 1;
        settle();
        tick();
        start = 0;
        settle();
        n_checks++; if (running !== 1'b0 || fault !== 1'b1) $display("FAIL ovf_start_ignored got run=%b fault=%b want 0/1", running, fault); else n_pass++;
        n_checks++; if (pc !== held) $display("FAIL ovf_pc_held got %h want %h", pc, held); else n_pass++;
        tick();
    endtask

    task automatic test_underflow_priority();
        restart();
        run_to(5);
        ret = 1;
        settle();
        n_checks++; if (bus.mux_sel !== 1'b0) $display("FAIL unf_sel got %b want 0", bus.mux_sel); else n_pass++;
        n_checks++; if (bus.mux_d1 !== 4'h0) $display("FAIL unf_d1 got %h want 0", bus.mux_d1); else n_pass++;
        tick();
        clear_in();
        settle();
        n_checks++; if (fault !== 1'b1) $display("FAIL unf_fault got %b want 1", fault); else n_pass++;
        n_checks++; if (pc !== 4'h5) $display("FAIL unf_pc got %h want 5", pc); else n_pass++;
        restart();
        call = 1;
        target = 4'hC;
        settle();
        tick();
        jmp = 1;
        call = 1;
        ret = 1;
        target = 4'hE;
        settle();
        n_checks++; if (bus.mux_d1 !== 4'h1) $display("FAIL prio_d1 got %h want 1", bus.mux_d1); else n_pass++;
        n_checks++; if (bus.mux_sel !== 1'b1) $display("FAIL prio_sel got %b want 1", bus.mux_sel); else n_pass++;
        tick();
        clear_in();
        settle();
        n_checks++; if (pc !== 4'h1) $display("FAIL prio_pc got %h want 1", pc); else n_pass++;
        n_checks++; if (sp !== '0) $display("FAIL prio_sp got %0d want 0", sp); else n_pass++;
        tick();
    endtask

    task automatic test_stall_halt();
        restart();
        run_to(6);
        stall = 1;
        jmp = 1;
        target = 4'hD;
        for (int i = 0; i < 3; i++) begin
            settle();
            n_checks++; if (pc !== 4'h6) $display("FAIL stall_pc cycle %0d got %h want 6", i, pc); else n_pass++;
            n_checks++; if (bus.mux_sel !== 1'b0) $display("FAIL stall_sel cycle %0d got %b want 0", i, bus.mux_sel); else n_pass++;
            tick();
        end
        clear_in();
        settle();
        n_checks++; if (pc !== 4'h6) $display("FAIL stall_release_pc got %h want 6", pc); else n_pass++;
        tick();
        halt = 1;
        settle();
        tick();
        clear_in();
        settle();
        n_checks++; if (pc !== 4'h8 || running !== 1'b0) $display("FAIL halt_pc got pc=%h run=%b want 8/0", pc, running); else n_pass++;
        tick();
        tick();
        settle();
        n_checks++; if (pc !== 4'h8) $display("FAIL halt_hold_pc got %h want 8", pc); else n_pass++;
        tick();
        start = 1;
        settle();
        tick();
        start = 0;
        settle();
        n_checks++; if (running !== 1'b1 || pc !== 4'h8) $display("FAIL resume_state got pc=%h run=%b want 8/1", pc, running); else n_pass++;
        tick();
        settle();
        n_checks++; if (pc !== 4'h9) $display("FAIL resume_pc got %h want 9", pc); else n_pass++;
        halt = 1;
        stall = 1;
        tick();
        clear_in();
        settle();
        n_checks++; if (running !== 1'b1 || pc !== 4'h9) $display("FAIL halt_stall got pc=%h run=%b want 9/1", pc, running); else n_pass++;
        call = 1;
        target = 4'h4;
        tick();
        reset = 1;
        call = 1;
        target = 4'h5;
        settle();
        tick();
        clear_in();
        settle();
        n_checks++; if (pc !== 4'h0 || sp !== '0) $display("FAIL reset_mid_call got pc=%h sp=%0d want 0/0", pc, sp); else n_pass++;
        n_checks++; if (running !== 1'b0 || fault !== 1'b0) $display("FAIL reset_mid_call_state got run=%b fault=%b want 0/0", running, fault); else n_pass++;
        tick();
    endtask

    task automatic test_random();
        restart();
        for (int i = 0; i < 400; i++) begin
            reset  = ($urandom_range(63) == 0);
            start  = (!m_run && $urandom_range(3) == 0);
            stall  = ($urandom_range(7) == 0);
            halt   = ($urandom_range(31) == 0);
            jmp    = ($urandom_range(5) == 0);
            call   = ($urandom_range(4) == 0);
            ret    = ($urandom_range(4) == 0);
            target = AW'($urandom);
            if (m_fault && $urandom_range(5) == 0) reset = 1;
            settle();
            n_checks++; if (pc !== exp_pc) $display("FAIL rnd_pc iter %0d got %h want %h", i, pc, exp_pc); else n_pass++;
            n_checks++; if (sp !== exp_sp) $display("FAIL rnd_sp iter %0d got %0d want %0d", i, sp, exp_sp); else n_pass++;
            n_checks++; if (running !== exp_run) $display("FAIL rnd_running iter %0d got %b want %b", i, running, exp_run); else n_pass++;
            n_checks++; if (fault !== exp_fault) $display("FAIL rnd_fault iter %0d got %b want %b", i, fault, exp_fault); else n_pass++;
            n_checks++; if (bus.mux_d0 !== exp_d0) $display("FAIL rnd_d0 iter %0d got %h want %h", i, bus.mux_d0, exp_d0); else n_pass++;
            n_checks++; if (bus.mux_d1 !== exp_d1) $display("FAIL rnd_d1 iter %0d got %h want %h", i, bus.mux_d1, exp_d1); else n_pass++;
            n_checks++; if (bus.mux_sel !== exp_sel) $display("FAIL rnd_sel iter %0d got %b want %b", i, bus.mux_sel, exp_sel); else n_pass++;
            tick();
        end
        clear_in();
    endtask

    initial begin
        clear_in();
        model_reset();
        reset = 1;
        #1;
        test_reset();
        test_sequential();
        test_jump();
        test_call_ret();
        test_overflow();
        test_underflow_priority();
        test_stall_halt();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
